// File: rtl/plugin_gray_threshold_pkg.sv
// Shared types and constants for the gray-threshold accelerator.
// Used by plugin_gray_threshold and (under GRAY_THRESH_HIST_EN) gray_histogram.
package plugin_gray_threshold_pkg;

    typedef enum logic [2:0] {
        TH_IDLE   = 3'd0,
        TH_READ   = 3'd1,
        TH_WRITE  = 3'd2,
        TH_NEXT   = 3'd3,
        TH_FINISH = 3'd4
    } thresh_state_t;

    localparam logic [31:0] THRESH_WHITE_WORD = 32'hFFFF_FF00;
    localparam logic [31:0] THRESH_BLACK_WORD = 32'h0000_0000;

    localparam int HIST_BINS = 16;

endpackage

// File: rtl/plugin_gray_threshold_hist.sv
// 16-bin histogram of the gray value's upper nibble, with combinational
// readback of one selected bin. Only instantiated under GRAY_THRESH_HIST_EN.
module gray_histogram
    import plugin_gray_threshold_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             inc_en,
    input  logic [3:0]       bin,
    input  logic [3:0]       sel,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] bin_q [HIST_BINS];
    logic [CNT_W-1:0] bin_d [HIST_BINS];

    genvar gi;
    generate
        for (gi = 0; gi < HIST_BINS; gi++) begin : g_bin
            // Clear wins over a coincident increment; a start never overlaps a READ.
            always_comb begin
                bin_d[gi] = bin_q[gi];
                if (clear) begin
                    bin_d[gi] = '0;
                end else if (inc_en && (bin == 4'(gi))) begin
                    bin_d[gi] = bin_q[gi] + CNT_W'(1);
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    bin_q[gi] <= '0;
                end else begin
                    bin_q[gi] <= bin_d[gi];
                end
            end
        end
    endgenerate

    assign count = bin_q[sel];

endmodule

// File: rtl/plugin_gray_threshold.sv
// Memory-mapped gray-to-binary threshold stage: reads {g,g,g,0} words, writes
// white/black words and counts white pixels. Optional histogram: GRAY_THRESH_HIST_EN.
module plugin_gray_threshold
    import plugin_gray_threshold_pkg::*;
#(
    parameter int STRIDE = 4,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    input  logic [31:0]      in_start_addr,
    input  logic [31:0]      out_start_addr,
    input  logic [31:0]      width,
    input  logic [31:0]      height,
    input  logic [7:0]       threshold,
    output logic [CNT_W-1:0] progress,
    output logic [CNT_W-1:0] white_count,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_ready
`ifdef GRAY_THRESH_HIST_EN
    ,
    input  logic [3:0]       hist_sel,
    output logic [CNT_W-1:0] hist_count
`endif
);

    thresh_state_t    state_q, state_d;
    logic [31:0]      in_base_q, in_base_d;
    logic [31:0]      out_base_q, out_base_d;
    logic [7:0]       thr_q, thr_d;
    logic [CNT_W-1:0] total_q, total_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] progress_q, progress_d;
    logic [CNT_W-1:0] white_cnt_q, white_cnt_d;
    logic             white_q, white_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [63:0]      total_full;
    logic [CNT_W-1:0] total_calc;
    logic [31:0]      pix_off;

    assign total_full = 64'(width) * 64'(height);
    assign total_calc = CNT_W'(total_full);

    // Address/data registers are loaded from next-state values, so they are
    // already valid in the first cycle of READ/WRITE and frozen while stalled.
    assign pix_off = 32'(idx_d) * 32'(STRIDE);

    always_comb begin
        state_d     = state_q;
        in_base_d   = in_base_q;
        out_base_d  = out_base_q;
        thr_d       = thr_q;
        total_d     = total_q;
        idx_d       = idx_q;
        progress_d  = progress_q;
        white_cnt_d = white_cnt_q;
        white_d     = white_q;

        case (state_q)
            TH_IDLE: begin
                if (start) begin
                    in_base_d   = in_start_addr;
                    out_base_d  = out_start_addr;
                    thr_d       = threshold;
                    total_d     = total_calc;
                    idx_d       = '0;
                    progress_d  = '0;
                    white_cnt_d = '0;
                    state_d     = (total_calc == '0) ? TH_FINISH : TH_READ;
                end
            end
            TH_READ: begin
                if (mem_ready) begin
                    white_d = (mem_rdata[31:24] >= thr_q);
                    state_d = TH_WRITE;
                end
            end
            TH_WRITE: begin
                if (mem_ready) begin
                    progress_d  = progress_q + CNT_W'(1);
                    white_cnt_d = white_cnt_q + CNT_W'(white_q);
                    state_d     = TH_NEXT;
                end
            end
            TH_NEXT: begin
                if (idx_q == total_q - CNT_W'(1)) begin
                    state_d = TH_FINISH;
                end else begin
                    idx_d   = idx_q + CNT_W'(1);
                    state_d = TH_READ;
                end
            end
            TH_FINISH: begin
                state_d = TH_IDLE;
            end
            default: begin
                state_d = TH_IDLE;
            end
        endcase

        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (state_d == TH_READ) begin
            addr_d = in_base_d + pix_off;
        end else if (state_d == TH_WRITE) begin
            addr_d  = out_base_d + pix_off;
            wdata_d = white_d ? THRESH_WHITE_WORD : THRESH_BLACK_WORD;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= TH_IDLE;
            in_base_q   <= '0;
            out_base_q  <= '0;
            thr_q       <= '0;
            total_q     <= '0;
            idx_q       <= '0;
            progress_q  <= '0;
            white_cnt_q <= '0;
            white_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            in_base_q   <= in_base_d;
            out_base_q  <= out_base_d;
            thr_q       <= thr_d;
            total_q     <= total_d;
            idx_q       <= idx_d;
            progress_q  <= progress_d;
            white_cnt_q <= white_cnt_d;
            white_q     <= white_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
        end
    end

    assign mem_req     = (state_q == TH_READ) || (state_q == TH_WRITE);
    assign mem_we      = (state_q == TH_WRITE);
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign busy        = (state_q == TH_READ) || (state_q == TH_WRITE) || (state_q == TH_NEXT);
    assign done        = (state_q == TH_FINISH);
    assign progress    = progress_q;
    assign white_count = white_cnt_q;

    // Only the replicated gray byte in [31:24] carries information.
    logic unused_rdata;
    assign unused_rdata = ^mem_rdata[23:0];

`ifdef GRAY_THRESH_HIST_EN
    logic hist_clear;
    logic hist_inc;

    assign hist_clear = (state_q == TH_IDLE) && start;
    assign hist_inc   = (state_q == TH_READ) && mem_ready;

    gray_histogram #(
        .CNT_W (CNT_W)
    ) u_hist (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (hist_clear),
        .inc_en  (hist_inc),
        .bin     (mem_rdata[31:28]),
        .sel     (hist_sel),
        .count   (hist_count)
    );
`endif

endmodule
